sev_seg_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed seven-segment driver for an N-digit common-anode display.
- Holds a hex value, decodes one digit per scan slot and drives the active-low segment, decimal-point and anode lines.
- Adds tear-free value loading at frame boundaries, leading-zero suppression, per-digit blink and decimal points.
- Sits between the datapath or debug registers and the board display pins.

---
 rtl/sev_seg_scan_ctrl_pkg.sv | 29 ++
 rtl/sev_seg_scan_ctrl_if.sv | 25 ++
 rtl/sev_seg_scan_ctrl_hex_glyph_decode.sv | 35 +++
 rtl/sev_seg_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sev_seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Glyphs are active-high in abcdefg order, so bit 0 (leftmost) is segment a.
package sev_seg_scan_ctrl_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam logic [0:6] GLYPH_0 = 7'b1111110;
    localparam logic [0:6] GLYPH_1 = 7'b0110000;
    localparam logic [0:6] GLYPH_2 = 7'b1101101;
    localparam logic [0:6] GLYPH_3 = 7'b1111001;
    localparam logic [0:6] GLYPH_4 = 7'b0110011;
    localparam logic [0:6] GLYPH_5 = 7'b1011011;
    localparam logic [0:6] GLYPH_6 = 7'b1011111;
    localparam logic [0:6] GLYPH_7 = 7'b1110000;
    localparam logic [0:6] GLYPH_8 = 7'b1111111;
    localparam logic [0:6] GLYPH_9 = 7'b1110011;
    localparam logic [0:6] GLYPH_A = 7'b1110111;
    localparam logic [0:6] GLYPH_B = 7'b0011111;
    localparam logic [0:6] GLYPH_C = 7'b1001110;
    localparam logic [0:6] GLYPH_D = 7'b0111101;
    localparam logic [0:6] GLYPH_E = 7'b1001111;
    localparam logic [0:6] GLYPH_F = 7'b1000111;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sev_seg_scan_ctrl_if.sv
// Display-side bundle: load/config inputs towards the controller, pin-level outputs back.
interface sev_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blink_en;
    logic                      lz_suppress;
    logic                      enable;
    logic [0:6]                seg_n;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_done;

    modport master (
        output load, value, dp_in, blink_en, lz_suppress, enable,
        input  seg_n, dp_n, an_n, frame_done
    );

    modport slave (
        input  load, value, dp_in, blink_en, lz_suppress, enable,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/sev_seg_scan_ctrl_hex_glyph_decode.sv
// Combinational hex nibble to active-low segment pattern (bit 0 = segment a).
module hex_glyph_decode
    import sev_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [0:6] seg_n_o
);

    logic [0:6] glyph_s;

    always_comb begin
        glyph_s = 7'b0000000;
        case (nibble_i)
            4'h0:    glyph_s = GLYPH_0;
            4'h1:    glyph_s = GLYPH_1;
            4'h2:    glyph_s = GLYPH_2;
            4'h3:    glyph_s = GLYPH_3;
            4'h4:    glyph_s = GLYPH_4;
            4'h5:    glyph_s = GLYPH_5;
            4'h6:    glyph_s = GLYPH_6;
            4'h7:    glyph_s = GLYPH_7;
            4'h8:    glyph_s = GLYPH_8;
            4'h9:    glyph_s = GLYPH_9;
            4'hA:    glyph_s = GLYPH_A;
            4'hB:    glyph_s = GLYPH_B;
            4'hC:    glyph_s = GLYPH_C;
            4'hD:    glyph_s = GLYPH_D;
            4'hE:    glyph_s = GLYPH_E;
            4'hF:    glyph_s = GLYPH_F;
            default: glyph_s = 7'b0000000;
        endcase
        seg_n_o = ~glyph_s;
    end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-aligned
// value loading, leading-zero blanking, per-digit blink and decimal points.
module sev_seg_scan_ctrl
    import sev_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    sev_seg_scan_ctrl_if.slave bus
);

    localparam int DW = idx_width(NUM_DIGITS);
    localparam int RW = idx_width(REFRESH_DIV);
    localparam int BW = idx_width(BLINK_DIV);

    localparam logic [DW-1:0] DIGIT_LAST   = DW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0][3:0] value_s;
    logic [NUM_DIGITS-1:0][3:0] shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0][3:0] active_value_q, active_value_d;
    logic [NUM_DIGITS-1:0]      shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0]      shadow_blink_q, shadow_blink_d, active_blink_q, active_blink_d;
    logic                       pending_q, pending_d;
    logic [RW-1:0]              refresh_cnt_q, refresh_cnt_d;
    logic [DW-1:0]              digit_q, digit_d;
    logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
    logic                       blink_phase_q, blink_phase_d;
    logic [0:6]                 seg_n_q, seg_n_d;
    logic                       dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]      an_n_q, an_n_d;
    logic                       frame_done_q, frame_done_d;

    logic                       wrap_s;
    logic                       commit_s;
    logic [0:6]                 glyph_n_s;
    logic [NUM_DIGITS-1:0]      zero_above_s;
    logic                       blink_blank_s;
    logic                       lz_blank_s;

    assign value_s  = bus.value;
    assign wrap_s   = bus.enable && (refresh_cnt_q == REFRESH_LAST) && (digit_q == DIGIT_LAST);
    // While blanked there is no visible frame to tear, so commit straight away.
    assign commit_s = wrap_s || !bus.enable;

    // Shadow capture and commit; using the _d shadow lets a load on the commit edge land directly.
    always_comb begin
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blink_d = shadow_blink_q;
        active_value_d = active_value_q;
        active_dp_d    = active_dp_q;
        active_blink_d = active_blink_q;
        pending_d      = pending_q;
        if (bus.load) begin
            shadow_value_d = value_s;
            shadow_dp_d    = bus.dp_in;
            shadow_blink_d = bus.blink_en;
        end else begin
            shadow_value_d = shadow_value_q;
        end
        if (commit_s) begin
            pending_d = 1'b0;
            if (pending_q || bus.load) begin
                active_value_d = shadow_value_d;
                active_dp_d    = shadow_dp_d;
                active_blink_d = shadow_blink_d;
            end else begin
                active_value_d = active_value_q;
            end
        end else begin
            pending_d = pending_q || bus.load;
        end
    end

    // Scan position and free-running blink timebase.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q;
        digit_d       = digit_q;
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (bus.enable) begin
            if (refresh_cnt_q == REFRESH_LAST) begin
                refresh_cnt_d = {RW{1'b0}};
                digit_d       = (digit_q == DIGIT_LAST) ? {DW{1'b0}} : digit_q + DW'(1);
            end else begin
                refresh_cnt_d = refresh_cnt_q + RW'(1);
            end
        end else begin
            refresh_cnt_d = refresh_cnt_q;
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = {BW{1'b0}};
            blink_phase_d = !blink_phase_q;
        end else begin
            blink_phase_d = blink_phase_q;
        end
    end

    hex_glyph_decode u_decode (
        .nibble_i (active_value_q[digit_q]),
        .seg_n_o  (glyph_n_s)
    );

    // zero_above_s[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        logic lz_acc;
        lz_acc       = 1'b1;
        zero_above_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_acc          = lz_acc && (active_value_q[i] == 4'h0);
            zero_above_s[i] = lz_acc;
        end
    end

    assign blink_blank_s = blink_phase_q && active_blink_q[digit_q];
    assign lz_blank_s    = bus.lz_suppress && (digit_q != {DW{1'b0}}) && zero_above_s[digit_q];

    // Output pattern for the current slot; a blanked digit keeps its anode driven.
    always_comb begin
        seg_n_d      = SEG_BLANK;
        dp_n_d       = 1'b1;
        an_n_d       = {NUM_DIGITS{1'b1}};
        frame_done_d = wrap_s;
        if (bus.enable) begin
            an_n_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_q);
            seg_n_d = (blink_blank_s || lz_blank_s) ? SEG_BLANK : glyph_n_s;
            dp_n_d  = blink_blank_s ? 1'b1 : !active_dp_q[digit_q];
        end else begin
            an_n_d  = {NUM_DIGITS{1'b1}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_value_q <= '0;
            shadow_dp_q    <= {NUM_DIGITS{1'b0}};
            shadow_blink_q <= {NUM_DIGITS{1'b0}};
            active_value_q <= '0;
            active_dp_q    <= {NUM_DIGITS{1'b0}};
            active_blink_q <= {NUM_DIGITS{1'b0}};
            pending_q      <= 1'b0;
            refresh_cnt_q  <= {RW{1'b0}};
            digit_q        <= {DW{1'b0}};
            blink_cnt_q    <= {BW{1'b0}};
            blink_phase_q  <= 1'b0;
            seg_n_q        <= SEG_BLANK;
            dp_n_q         <= 1'b1;
            an_n_q         <= {NUM_DIGITS{1'b1}};
            frame_done_q   <= 1'b0;
        end else begin
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blink_q <= shadow_blink_d;
            active_value_q <= active_value_d;
            active_dp_q    <= active_dp_d;
            active_blink_q <= active_blink_d;
            pending_q      <= pending_d;
            refresh_cnt_q  <= refresh_cnt_d;
            digit_q        <= digit_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            seg_n_q        <= seg_n_d;
            dp_n_q         <= dp_n_d;
            an_n_q         <= an_n_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16.
module tb_sev_seg_scan_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    logic [0:6] exp_seg   [4];
    logic       exp_dp    [4];
    logic       exp_blink [4];

    sev_seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    sev_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the blink phase seen after edge n is ((n-1)/16)%2.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (bus.frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_fd_wait"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        bus.value    = v;
        bus.dp_in    = dp;
        bus.blink_en = bl;
        bus.load     = 1'b1;
        step(1);
        bus.load     = 1'b0;
    endtask

    // Call on the negedge where frame_done is high; ends on the next frame_done negedge.
    task automatic check_frame(input string tag);
        int         d;
        int         phase;
        logic [0:6] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        for (int k = 0; k < 16; k++) begin
            step(1);
            d     = k / 4;
            phase = ((cyc - 1) / 16) % 2;
            if (exp_blink[d] && (phase == 1)) begin
                e_seg = 7'b1111111;
                e_dp  = 1'b1;
            end else begin
                e_seg = exp_seg[d];
                e_dp  = exp_dp[d];
            end
            e_an = ~(4'b0001 << d);
            check_eq($sformatf("%s_k%0d_seg", tag, k), {25'd0, bus.seg_n}, {25'd0, e_seg});
            check_eq($sformatf("%s_k%0d_an", tag, k), {28'd0, bus.an_n}, {28'd0, e_an});
            check_eq($sformatf("%s_k%0d_dp", tag, k), {31'd0, bus.dp_n}, {31'd0, e_dp});
        end
        check_eq({tag, "_fd_period"}, {31'd0, bus.frame_done}, 32'd1);
    endtask

    task automatic set_exp(input logic [0:6] s0, input logic [0:6] s1,
                           input logic [0:6] s2, input logic [0:6] s3,
                           input logic [3:0] dpn, input logic [3:0] bl);
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        for (int i = 0; i < 4; i++) begin
            exp_dp[i]    = dpn[i];
            exp_blink[i] = bl[i];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.load        = 1'b0;
        bus.value       = 16'h0000;
        bus.dp_in       = 4'b0000;
        bus.blink_en    = 4'b0000;
        bus.lz_suppress = 1'b0;
        bus.enable      = 1'b1;
        step(3);
        check_eq("rst_seg", {25'd0, bus.seg_n}, {25'd0, 7'b1111111});
        check_eq("rst_an", {28'd0, bus.an_n}, 32'hF);
        check_eq("rst_dp", {31'd0, bus.dp_n}, 32'd1);
        check_eq("rst_fd", {31'd0, bus.frame_done}, 32'd0);

        // Reset mid-scan: digit 2, refresh_cnt 3
        reset = 1'b0;
        step(11);
        check_eq("pre_rst_an", {28'd0, bus.an_n}, {28'd0, 4'b1011});
        reset = 1'b1;
        step(1);
        check_eq("mid_rst_seg", {25'd0, bus.seg_n}, {25'd0, 7'b1111111});
        check_eq("mid_rst_an", {28'd0, bus.an_n}, 32'hF);
        check_eq("mid_rst_dp", {31'd0, bus.dp_n}, 32'd1);
        reset = 1'b0;
        step(1);
        check_eq("post_rst_seg", {25'd0, bus.seg_n}, {25'd0, 7'b0000001});
        check_eq("post_rst_an", {28'd0, bus.an_n}, {28'd0, 4'b1110});

        // Load is held in shadow until the frame wrap
        do_load(16'h1A3F, 4'b0000, 4'b0000);
        check_eq("pre_commit_seg0", {25'd0, bus.seg_n}, {25'd0, 7'b0000001});
        step(10);
        check_eq("pre_commit_an2", {28'd0, bus.an_n}, {28'd0, 4'b1011});
        check_eq("pre_commit_seg2", {25'd0, bus.seg_n}, {25'd0, 7'b0000001});
        wait_frame_done("f1");
        set_exp(7'b0111000, 7'b0000110, 7'b0001000, 7'b1001111, 4'b1111, 4'b0000);
        check_frame("val1a3f_a");
        check_frame("val1a3f_b");

        // Leading-zero suppression
        bus.lz_suppress = 1'b1;
        do_load(16'h0005, 4'b0000, 4'b0000);
        wait_frame_done("lz");
        set_exp(7'b0100100, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1111, 4'b0000);
        check_frame("lz_on");
        bus.lz_suppress = 1'b0;
        set_exp(7'b0100100, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1111, 4'b0000);
        check_frame("lz_off");

        // Blink on digit 0, decimal point on digit 2
        do_load(16'h1A3F, 4'b0100, 4'b0001);
        wait_frame_done("blink");
        set_exp(7'b0111000, 7'b0000110, 7'b0001000, 7'b1001111, 4'b1011, 4'b0001);
        for (int f = 0; f < 4; f++) check_frame($sformatf("blink_f%0d", f));

        // Last load before the wrap wins
        do_load(16'h1111, 4'b0000, 4'b0000);
        step(2);
        do_load(16'h2222, 4'b0000, 4'b0000);
        wait_frame_done("last");
        set_exp(7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010, 4'b1111, 4'b0000);
        check_frame("last_load");

        // Load exactly on the wrap edge commits on that edge
        step(15);
        do_load(16'h4321, 4'b0000, 4'b0000);
        check_eq("wrap_load_fd", {31'd0, bus.frame_done}, 32'd1);
        set_exp(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b1111, 4'b0000);
        check_frame("wrap_load");

        // Disable mid-frame: blank at once, commit pending load, resume held position
        step(5);
        do_load(16'h8888, 4'b0000, 4'b0000);
        bus.enable = 1'b0;
        step(1);
        check_eq("dis_seg", {25'd0, bus.seg_n}, {25'd0, 7'b1111111});
        check_eq("dis_an", {28'd0, bus.an_n}, 32'hF);
        check_eq("dis_dp", {31'd0, bus.dp_n}, 32'd1);
        check_eq("dis_fd", {31'd0, bus.frame_done}, 32'd0);
        step(3);
        check_eq("dis_hold_an", {28'd0, bus.an_n}, 32'hF);
        bus.enable = 1'b1;
        step(1);
        check_eq("reen_an_a", {28'd0, bus.an_n}, {28'd0, 4'b1101});
        check_eq("reen_seg", {25'd0, bus.seg_n}, {25'd0, 7'b0000000});
        step(1);
        check_eq("reen_an_b", {28'd0, bus.an_n}, {28'd0, 4'b1101});
        step(1);
        check_eq("reen_an_c", {28'd0, bus.an_n}, {28'd0, 4'b1011});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
